latch_write_seq: RTL and testbench

Upstream driver for the gate-level D latch array. Accepts data words over a valid/ready handshake and drives the latch D inputs and the latch enable (the latch `clk` input) with programmable setup, pulse and hold windows. After the hold window it reads back the latch Q outputs, compares them against the written word, and reports done/error. It sits between the test/control logic and the latch bank, and gives the latch bank clean, timed write strobes.

---
 rtl/latch_write_seq.sv | 100 ++++++++++
 tb/tb_latch_write_seq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/latch_write_seq.sv
// latch_write_seq: timed setup/pulse/hold write strobes to a latch bank with readback check
module latch_write_seq #(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 3,
  parameter int HOLD_CYC  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] lat_d,
  output logic             lat_en,
  input  logic [WIDTH-1:0] lat_q,
  output logic             done,
  output logic             err,
  output logic [7:0]       err_cnt
);
  if (SETUP_CYC < 1 || SETUP_CYC > 15 || PULSE_CYC < 1 || PULSE_CYC > 15 ||
      HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_bad_param
    $error("latch_write_seq: SETUP_CYC/PULSE_CYC/HOLD_CYC must be 1..15");
  end
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, CHECK} state_t;
  localparam logic [3:0] S_LD = 4'(SETUP_CYC - 1);
  localparam logic [3:0] P_LD = 4'(PULSE_CYC - 1);
  localparam logic [3:0] H_LD = 4'(HOLD_CYC - 1);
  state_t           state, state_nx;
  logic [3:0]       cnt, cnt_nx;
  logic [WIDTH-1:0] lat_d_nx;
  logic             lat_en_nx, done_nx, err_nx;
  logic [7:0]       err_cnt_nx;
  logic             last;
  assign in_ready = (state == IDLE) && !rst;
  assign last     = cnt == 4'd0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      lat_d   <= '0;
      lat_en  <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      lat_d   <= lat_d_nx;
      lat_en  <= lat_en_nx;
      done    <= done_nx;
      err     <= err_nx;
      err_cnt <= err_cnt_nx;
    end
  end
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt - 4'd1;
    lat_d_nx   = lat_d;
    lat_en_nx  = lat_en;
    done_nx    = 1'b0;
    err_nx     = 1'b0;
    err_cnt_nx = err_cnt;
    case (state)
      IDLE: begin
        cnt_nx = cnt;
        if (in_valid) begin
          lat_d_nx = in_data;
          cnt_nx   = S_LD;
          state_nx = SETUP;
        end
      end
      SETUP: if (last) begin
        cnt_nx    = P_LD;
        lat_en_nx = 1'b1;
        state_nx  = PULSE;
      end
      PULSE: if (last) begin
        cnt_nx    = H_LD;
        lat_en_nx = 1'b0;
        state_nx  = HOLD;
      end
      HOLD: if (last) begin
        cnt_nx   = '0;
        state_nx = CHECK;
      end
      CHECK: begin
        cnt_nx     = '0;
        done_nx    = 1'b1;
        err_nx     = lat_q != lat_d;
        err_cnt_nx = err_cnt + 8'(err_nx && !(&err_cnt));
        state_nx   = IDLE;
      end
      default: begin
        cnt_nx    = '0;
        lat_en_nx = 1'b0;
        state_nx  = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_latch_write_seq.sv
// tb_latch_write_seq: random and directed checks of two latch_write_seq instances against a timeline model
module tb_latch_write_seq;
  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, force_q = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic [1:0] rdy, en, dn, er;
  logic [1:0][7:0] ld, lq, ec;
  logic [7:0] q_mem [2] = '{8'h00, 8'h00};
  int total = 0, bad = 0, cyc = 0;
  int sc [2] = '{2, 1};
  int pc [2] = '{3, 1};
  int hc [2] = '{2, 1};
  bit act [2] = '{0, 0};
  bit derr [2] = '{0, 0};
  int acc [2] = '{0, 0};
  int dcyc [2] = '{0, 0};
  int done_at [2] = '{-1, -1};
  int mcnt [2] = '{0, 0};
  logic [7:0] md [2] = '{8'h00, 8'h00};
  int en_first [2], en_n [2], done_j [2];
  bit err0;

  always #5 clk = ~clk;

  latch_write_seq u0 (.clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy[0]),
    .lat_d(ld[0]), .lat_en(en[0]), .lat_q(lq[0]), .done(dn[0]), .err(er[0]), .err_cnt(ec[0]));
  latch_write_seq #(.WIDTH(8), .SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1)) u1 (.clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(rdy[1]), .lat_d(ld[1]), .lat_en(en[1]),
    .lat_q(lq[1]), .done(dn[1]), .err(er[1]), .err_cnt(ec[1]));

  // Latch bank stand-in: Q tracks D while enable is high, otherwise holds.
  always @(negedge clk) for (int i = 0; i < 2; i++) if (en[i]) q_mem[i] = ld[i];
  always_comb for (int i = 0; i < 2; i++) lq[i] = force_q ? 8'h00 : q_mem[i];

  task automatic chk(input int u, input string n, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL u%0d %s got=%0d want=%0d at cycle %0d", u, n, a, e, cyc);
    end
  endtask

  // Timeline model: an accepted word at edge k fixes its enable window and done cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        act[i] = 0; md[i] = 8'h00; mcnt[i] = 0; done_at[i] = -1;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (act[i] && cyc == dcyc[i] - 1) begin
          derr[i] = lq[i] != md[i];
          done_at[i] = cyc + 1;
          if (derr[i] && mcnt[i] < 255) mcnt[i]++;
        end
        if (in_valid && (!act[i] || cyc >= dcyc[i])) begin
          act[i] = 1; acc[i] = cyc; md[i] = in_data;
          dcyc[i] = cyc + sc[i] + pc[i] + hc[i] + 2;
        end
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk(i, "in_ready", int'(rdy[i]), int'(!rst && (!act[i] || cyc >= dcyc[i])));
      chk(i, "lat_en", int'(en[i]), int'(act[i] && cyc >= acc[i] + sc[i] + 1 && cyc <= acc[i] + sc[i] + pc[i]));
      chk(i, "lat_d", int'(ld[i]), int'(md[i]));
      chk(i, "done", int'(dn[i]), int'(cyc == done_at[i]));
      chk(i, "err", int'(er[i]), int'(cyc == done_at[i] && derr[i]));
      chk(i, "err_cnt", int'(ec[i]), mcnt[i]);
    end
  end

  task automatic wait_idle();
    int w = 0;
    while (rdy != 2'b11 && w < 40) begin @(negedge clk); w++; end
    chk(0, "idle_timeout", int'(w < 40), 1);
  endtask

  task automatic send(input logic [7:0] data, input bit noise);
    wait_idle();
    en_first = '{0, 0}; en_n = '{0, 0}; done_j = '{0, 0}; err0 = 0;
    in_valid = 1'b1; in_data = data;
    @(negedge clk);
    in_valid = 1'b0;
    chk(0, "accept_lat_d", int'(ld[0]), int'(data));
    for (int j = 2; j <= 12; j++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (en[i]) begin en_n[i]++; if (en_first[i] == 0) en_first[i] = j; end
        if (dn[i] && done_j[i] == 0) begin done_j[i] = j; if (i == 0) err0 = er[0]; end
      end
      if (noise) begin in_valid = (j <= 7) ? j[0] : 1'b0; in_data = 8'hFF; end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int found, dcount;
    #1 rst = 1'b1;
    @(negedge clk);
    chk(0, "rst_ready", int'(rdy[0]), 0);
    chk(0, "rst_lat_d", int'(ld[0]), 0);
    chk(0, "rst_err_cnt", int'(ec[0]), 0);
    @(negedge clk); #1 rst = 1'b0;
    @(negedge clk);
    send(8'hA5, 0);
    chk(0, "t1_en_first", en_first[0], 3);
    chk(0, "t1_en_len", en_n[0], 3);
    chk(0, "t1_done_cyc", done_j[0], 9);
    chk(0, "t1_err", int'(err0), 0);
    chk(0, "t1_err_cnt", int'(ec[0]), 0);
    chk(1, "t5_en_first", en_first[1], 2);
    chk(1, "t5_en_len", en_n[1], 1);
    chk(1, "t5_done_cyc", done_j[1], 5);
    force_q = 1'b1;
    send(8'hA5, 0);
    chk(0, "t2_done_cyc", done_j[0], 9);
    chk(0, "t2_err", int'(err0), 1);
    chk(0, "t2_err_cnt", int'(ec[0]), 1);
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'($urandom_range(1, 255));
    end
    in_valid = 1'b0;
    repeat (12) @(negedge clk);
    chk(0, "t2_saturate", int'(ec[0]), 255);
    chk(1, "t2_saturate", int'(ec[1]), 255);
    force_q = 1'b0;
    wait_idle();
    in_valid = 1'b1; in_data = 8'h01;
    @(negedge clk);
    in_data = 8'h02;
    chk(0, "t3_first", int'(ld[0]), 1);
    found = 0;
    for (int j = 2; j <= 15 && found == 0; j++) begin
      @(negedge clk);
      if (dn[0]) begin found = 1; chk(0, "t3_ready_on_done", int'(rdy[0]), 1); end
      else chk(0, "t3_lat_d_held", int'(ld[0]), 1);
    end
    chk(0, "t3_done_seen", found, 1);
    @(negedge clk);
    chk(0, "t3_second", int'(ld[0]), 2);
    in_valid = 1'b0;
    wait_idle();
    in_valid = 1'b1; in_data = 8'h3C;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk(0, "t4_mid_pulse", int'(en[0]), 1);
    #2 rst = 1'b1;
    #1;
    chk(0, "t4_async_en", int'(en[0]), 0);
    chk(0, "t4_async_lat_d", int'(ld[0]), 0);
    chk(0, "t4_async_err_cnt", int'(ec[0]), 0);
    @(negedge clk); @(negedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk(0, "t4_ready_after", int'(rdy[0]), 1);
    dcount = 0;
    repeat (12) begin @(negedge clk); dcount += int'(dn[0]); end
    chk(0, "t4_no_done", dcount, 0);
    send(8'h5A, 1);
    chk(0, "t6_done_cyc", done_j[0], 9);
    chk(0, "t6_err", int'(err0), 0);
    chk(0, "t6_en_len", en_n[0], 3);
    chk(0, "t6_lat_d_kept", int'(ld[0]), 8'h5A);
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      in_data = 8'($urandom);
      force_q = $urandom_range(0, 5) == 0;
      if (n == 700) begin #3 rst = 1'b1; @(negedge clk); #1 rst = 1'b0; end
    end
    in_valid = 1'b0;
    repeat (15) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
